// File: rtl/stopwatch_clock.sv
// Count-up BCD stopwatch (hh:mm:ss.mmm) with run/hold, clear, saturation and lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap outputs are tied to 0.
module stopwatch_clock #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        Stop_Start,
  input  logic        Clear,
  input  logic        Lap,
  output logic [11:0] Milli_o,
  output logic [7:0]  Seconds_o,
  output logic [7:0]  Minutes_o,
  output logic [7:0]  Hours_o,
  output logic [11:0] Lap_Milli_o,
  output logic [7:0]  Lap_Seconds_o,
  output logic [7:0]  Lap_Minutes_o,
  output logic [7:0]  Lap_Hours_o,
  output logic        Lap_Valid_o,
  output logic        Overflow_o
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [11:0] milli_q, milli_d;
  logic [7:0]  sec_q, sec_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  hr_q, hr_d;
  logic        ovf_q, ovf_d;

  logic        run, tick, at_max;
  logic [4:0]  c_ms0, c_ms1, c_ms2, c_s0, c_s1, c_m0, c_m1, c_h0, c_h1;

  // Returns {carry_out, next_digit}; the digit wraps to 0 after reaching lim.
  function automatic logic [4:0] digit_inc(input logic [3:0] v, input logic [3:0] lim,
                                           input logic cin);
    logic [4:0] r;
    r = {1'b0, v};
    if (cin) begin
      if (v == lim) r = 5'h10;
      else          r = {1'b0, v + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    run    = Stop_Start && !ovf_q;
    tick   = run && (div_q == DIV_LAST);
    at_max = ({hr_q, min_q, sec_q, milli_q} == {8'h23, 8'h59, 8'h59, 12'h999});

    c_ms0 = digit_inc(milli_q[3:0],  4'd9, 1'b1);
    c_ms1 = digit_inc(milli_q[7:4],  4'd9, c_ms0[4]);
    c_ms2 = digit_inc(milli_q[11:8], 4'd9, c_ms1[4]);
    c_s0  = digit_inc(sec_q[3:0],    4'd9, c_ms2[4]);
    c_s1  = digit_inc(sec_q[7:4],    4'd5, c_s0[4]);
    c_m0  = digit_inc(min_q[3:0],    4'd9, c_s1[4]);
    c_m1  = digit_inc(min_q[7:4],    4'd5, c_m0[4]);
    // Hours only reach 23 with a carry pending at full saturation, handled below.
    c_h0  = digit_inc(hr_q[3:0],     4'd9, c_m1[4]);
    c_h1  = digit_inc(hr_q[7:4],     4'd2, c_h0[4]);

    div_d   = div_q;
    milli_d = milli_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    ovf_d   = ovf_q;

    if (run) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    if (tick) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else begin
        milli_d = {c_ms2[3:0], c_ms1[3:0], c_ms0[3:0]};
        sec_d   = {c_s1[3:0], c_s0[3:0]};
        min_d   = {c_m1[3:0], c_m0[3:0]};
        hr_d    = {c_h1[3:0], c_h0[3:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn || Clear) begin
      div_q   <= '0;
      milli_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      milli_q <= milli_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Milli_o    = milli_q;
  assign Seconds_o  = sec_q;
  assign Minutes_o  = min_q;
  assign Hours_o    = hr_q;
  assign Overflow_o = ovf_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_q;
  logic        lap_edge;
  logic [11:0] lap_ms_q;
  logic [7:0]  lap_sec_q, lap_min_q, lap_hr_q;
  logic        lap_valid_q;

  assign lap_edge = Lap && !lap_q;

  // The edge register keeps following Lap during Clear so a held Lap cannot fire afterwards.
  always_ff @(posedge clk) begin
    if (resetn) begin
      lap_q       <= 1'b0;
      lap_ms_q    <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hr_q    <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_q <= Lap;
      if (Clear) begin
        lap_ms_q    <= '0;
        lap_sec_q   <= '0;
        lap_min_q   <= '0;
        lap_hr_q    <= '0;
        lap_valid_q <= 1'b0;
      end else if (lap_edge) begin
        lap_ms_q    <= milli_q;
        lap_sec_q   <= sec_q;
        lap_min_q   <= min_q;
        lap_hr_q    <= hr_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign Lap_Milli_o   = lap_ms_q;
  assign Lap_Seconds_o = lap_sec_q;
  assign Lap_Minutes_o = lap_min_q;
  assign Lap_Hours_o   = lap_hr_q;
  assign Lap_Valid_o   = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap    = Lap;
  assign Lap_Milli_o   = '0;
  assign Lap_Seconds_o = '0;
  assign Lap_Minutes_o = '0;
  assign Lap_Hours_o   = '0;
  assign Lap_Valid_o   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_clock.sv
// Directed bench for stopwatch_clock at TICK_DIV=4; lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_clock;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        Stop_Start = 1'b0;
  logic        Clear = 1'b0;
  logic        Lap = 1'b0;
  logic [11:0] Milli_o, Lap_Milli_o;
  logic [7:0]  Seconds_o, Minutes_o, Hours_o;
  logic [7:0]  Lap_Seconds_o, Lap_Minutes_o, Lap_Hours_o;
  logic        Lap_Valid_o, Overflow_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_clock #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .Stop_Start   (Stop_Start),
    .Clear        (Clear),
    .Lap          (Lap),
    .Milli_o      (Milli_o),
    .Seconds_o    (Seconds_o),
    .Minutes_o    (Minutes_o),
    .Hours_o      (Hours_o),
    .Lap_Milli_o  (Lap_Milli_o),
    .Lap_Seconds_o(Lap_Seconds_o),
    .Lap_Minutes_o(Lap_Minutes_o),
    .Lap_Hours_o  (Lap_Hours_o),
    .Lap_Valid_o  (Lap_Valid_o),
    .Overflow_o   (Overflow_o)
  );

  typedef struct {
    logic        ss;
    logic        clr;
    int          n;
    logic [11:0] ms;
    logic [7:0]  sec;
  } vec_t;

  vec_t tbl[15];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_live(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic [11:0] ms, input logic ovf);
    chk({tag, "_hr"},  {24'h0, Hours_o},   {24'h0, h});
    chk({tag, "_min"}, {24'h0, Minutes_o}, {24'h0, m});
    chk({tag, "_sec"}, {24'h0, Seconds_o}, {24'h0, s});
    chk({tag, "_ms"},  {20'h0, Milli_o},   {20'h0, ms});
    chk({tag, "_ovf"}, {31'h0, Overflow_o}, {31'h0, ovf});
  endtask

  task automatic chk_lap(input string tag, input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic [11:0] ms, input logic v);
    chk({tag, "_lhr"},  {24'h0, Lap_Hours_o},   {24'h0, h});
    chk({tag, "_lmin"}, {24'h0, Lap_Minutes_o}, {24'h0, m});
    chk({tag, "_lsec"}, {24'h0, Lap_Seconds_o}, {24'h0, s});
    chk({tag, "_lms"},  {20'h0, Lap_Milli_o},   {20'h0, ms});
    chk({tag, "_lval"}, {31'h0, Lap_Valid_o},   {31'h0, v});
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    cyc(1);
    Clear = 1'b0;
  endtask

  // Loads the live count directly; the force spans one edge with the counter held so the
  // flops themselves capture the value before release.
  task automatic preload(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic [11:0] ms);
    Stop_Start = 1'b0;
    force dut.hr_q    = h;
    force dut.min_q   = m;
    force dut.sec_q   = s;
    force dut.milli_q = ms;
    cyc(1);
    release dut.hr_q;
    release dut.min_q;
    release dut.sec_q;
    release dut.milli_q;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1,    12'h000, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 3999, 12'h999, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1,    12'h000, 8'h01};
    tbl[3]  = '{1'b0, 1'b1, 2,    12'h000, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 5,    12'h000, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 6,    12'h001, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 50,   12'h001, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1,    12'h001, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 1,    12'h002, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 3,    12'h002, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 1,    12'h003, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 2,    12'h003, 8'h00};
    tbl[12] = '{1'b1, 1'b1, 1,    12'h000, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 3,    12'h000, 8'h00};
    tbl[14] = '{1'b1, 1'b0, 1,    12'h001, 8'h00};

    resetn = 1'b1;
    cyc(2);
    chk_live("reset", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    chk_lap("reset", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    resetn = 1'b0;

    for (int i = 0; i < 15; i++) begin
      Stop_Start = tbl[i].ss;
      Clear      = tbl[i].clr;
      cyc(tbl[i].n);
      chk($sformatf("v%0d_ms", i),  {20'h0, Milli_o},   {20'h0, tbl[i].ms});
      chk($sformatf("v%0d_sec", i), {24'h0, Seconds_o}, {24'h0, tbl[i].sec});
      chk($sformatf("v%0d_min", i), {8'h0, Minutes_o, Hours_o}, 32'h0);
      chk($sformatf("v%0d_ovf", i), {31'h0, Overflow_o}, 32'h0);
    end
    Stop_Start = 1'b0;
    Clear      = 1'b0;

    // Full carry ripple into hours, then the 09->10 and 19->20 hour boundaries.
    do_clear();
    preload(8'h00, 8'h59, 8'h59, 12'h999);
    Stop_Start = 1'b1;
    cyc(3);
    chk_live("carry_pre", 8'h00, 8'h59, 8'h59, 12'h999, 1'b0);
    cyc(1);
    chk_live("carry", 8'h01, 8'h00, 8'h00, 12'h000, 1'b0);

    do_clear();
    preload(8'h09, 8'h59, 8'h59, 12'h999);
    Stop_Start = 1'b1;
    cyc(4);
    chk_live("hr10", 8'h10, 8'h00, 8'h00, 12'h000, 1'b0);

    do_clear();
    preload(8'h19, 8'h59, 8'h59, 12'h999);
    Stop_Start = 1'b1;
    cyc(4);
    chk_live("hr20", 8'h20, 8'h00, 8'h00, 12'h000, 1'b0);

    // Saturation at 23:59:59.999 and recovery through Clear.
    do_clear();
    preload(8'h23, 8'h59, 8'h59, 12'h998);
    Stop_Start = 1'b1;
    cyc(4);
    chk_live("sat_max", 8'h23, 8'h59, 8'h59, 12'h999, 1'b0);
    cyc(3);
    chk_live("sat_pre", 8'h23, 8'h59, 8'h59, 12'h999, 1'b0);
    cyc(1);
    chk_live("sat_hit", 8'h23, 8'h59, 8'h59, 12'h999, 1'b1);
    cyc(20);
    chk_live("sat_hold", 8'h23, 8'h59, 8'h59, 12'h999, 1'b1);
    Clear = 1'b1;
    cyc(1);
    chk_live("sat_clr", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    Clear = 1'b0;
    cyc(4);
    chk_live("sat_resume", 8'h00, 8'h00, 8'h00, 12'h001, 1'b0);

    do_clear();
    Stop_Start = 1'b1;
    cyc(23);
`ifdef STOPWATCH_LAP_EN
    chk_lap("lap_none", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    Lap = 1'b1;
    cyc(1);
    chk({"lap_tick", "_ms"}, {20'h0, Milli_o}, 32'h006);
    chk_lap("lap_tick", 8'h00, 8'h00, 8'h00, 12'h005, 1'b1);
    cyc(10);
    chk({"lap_held", "_ms"}, {20'h0, Milli_o}, 32'h008);
    chk_lap("lap_held", 8'h00, 8'h00, 8'h00, 12'h005, 1'b1);
    Lap = 1'b0;
    Stop_Start = 1'b0;
    cyc(1);
    Lap = 1'b1;
    cyc(1);
    chk_lap("lap_stop", 8'h00, 8'h00, 8'h00, 12'h008, 1'b1);
    Lap = 1'b0;
    cyc(1);
    Stop_Start = 1'b1;
    Clear = 1'b1;
    Lap = 1'b1;
    cyc(1);
    chk_live("clr_lap", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    chk_lap("clr_lap", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
`else
    for (int i = 0; i < 5; i++) begin
      Lap = 1'b1;
      cyc(1);
      Lap = 1'b0;
      cyc(1);
    end
    chk({"nolap", "_ms"}, {20'h0, Milli_o}, 32'h008);
    chk_lap("nolap", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    Clear = 1'b1;
    Lap = 1'b1;
    cyc(1);
    chk_live("clr_lap", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
    chk_lap("clr_lap", 8'h00, 8'h00, 8'h00, 12'h000, 1'b0);
`endif
    Clear = 1'b0;
    Lap = 1'b0;
    Stop_Start = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_clock.md
# stopwatch_clock

Count-up stopwatch: the count-up counterpart of the countdown timer in the multimode clock. It accumulates elapsed time in packed BCD, using the same digit layout as the timer outputs (ms, seconds, minutes, hours), so the existing display mux can show it unchanged. It supports run/stop, clear and lap capture. It sits beside the timer in the mode selector and shares the 100 MHz system clock.

## Interface
Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms tick; legal range ≥ 2.

Ports:
- clk, input, 1: system clock; all logic runs on the rising edge.
- resetn, input, 1: synchronous, active-high reset. The legacy port name is kept; asserting it high resets the block.
- Stop_Start, input, 1: level input. 1 = run, 0 = hold.
- Clear, input, 1: synchronous level input; zeroes the count.
- Lap, input, 1: lap request; the block acts on its rising edge.
- Milli_o, output, 12: BCD ms. [11:8] hundreds, [7:4] tens, [3:0] units; 000–999.
- Seconds_o, output, 8: BCD seconds 00–59. [7:4] tens, [3:0] units.
- Minutes_o, output, 8: BCD minutes 00–59.
- Hours_o, output, 8: BCD hours 00–23.
- Lap_Milli_o, Lap_Seconds_o, Lap_Minutes_o, Lap_Hours_o, output, 12/8/8/8: captured lap time, same encoding as the live outputs.
- Lap_Valid_o, output, 1: 1 once a lap has been captured since the last reset or clear.
- Overflow_o, output, 1: sticky flag; the count is saturated at 23:59:59.999.

## Operation
- Prescaler `div`: width is $clog2(TICK_DIV).
  - Counts only while Stop_Start=1 and Overflow_o=0.
  - On `div == TICK_DIV-1` it wraps to 0 and asserts the internal `tick` for one cycle.
  - Stop freezes `div` without zeroing it, so a resumed count keeps the partial millisecond.
- BCD ripple increment on `tick`:
  - ms units 9→0 carries into ms tens.
  - ms tens 9→0 carries into ms hundreds; hundreds 9→0 carries into seconds units.
  - Seconds units 9→0 carries into seconds tens; seconds tens 5→0 carries into minutes units.
  - Minutes follow the same rule as seconds; minutes tens 5→0 carries into hours.
  - Hours go 00→…→09→10→…→19→20→…→23. Units wrap 9→0 with a tens increment, except at 23.
- Saturation:
  - A tick that arrives with the count at 23:59:59.999 leaves all digits unchanged.
  - The same tick sets Overflow_o=1; the prescaler then halts.
- Every digit stays within legal BCD at all times. No digit ever holds A–F.
- Lap:
  - A registered copy of Lap gives the rising-edge detect.
  - On an edge, the Lap_* registers load the live values present at that clock edge, i.e. the pre-increment value if `tick` is in the same cycle.
  - Lap_Valid_o is set at the same time.
  - Lap works whether running or stopped.
- Clear:
  - Zeroes all live digits, `div`, Overflow_o, the Lap_* registers and Lap_Valid_o.
  - Clear holds everything at zero for as long as it is high, even with Stop_Start=1.
- Priority, highest first: resetn, Clear, lap capture / tick. Lap and tick are independent and can act in the same cycle.

## Timing
- Reset value of all outputs is 0: every BCD output, Lap_Valid_o and Overflow_o. `div` and the Lap edge register also reset to 0.
- Outputs are registered. A tick decided at edge N is visible after edge N.
- From Stop_Start rising (synchronous) to the first ms increment: exactly TICK_DIV clk cycles from the edge where Stop_Start is first sampled high, starting from `div=0`.
- Lap: Lap_* values and Lap_Valid_o update one cycle after the cycle in which Lap is first sampled high. A held Lap captures only once.
- Clear and resetn take effect at the next clk edge, with outputs zero after that edge. Asserting either mid-count abandons the partial tick.
- No combinational path from inputs to outputs.

## Configuration
- STOPWATCH_LAP_EN:
  - Defined: lap edge detect, Lap_* registers and Lap_Valid_o are implemented as above.
  - Undefined: the Lap input is ignored. Lap_* outputs and Lap_Valid_o are tied to constant 0, and no lap flops are synthesised.
  - Ports are present in both builds.

## Test plan
All scenarios use TICK_DIV=4 for simulation.
- Reset and run: hold resetn 2 cycles, then Stop_Start=1 for 4000 cycles → Milli_o=12'h000, Seconds_o=8'h01, no other change. Before the run, all outputs are 0.
- Carry chain: run to 00:59:59.999 (preload by running), one more tick → Hours_o=8'h01, Minutes_o=0, Seconds_o=0, Milli_o=0, in a single update.
- Stop/resume: run 6 cycles (Milli_o=001, div=2), stop 50 cycles (no change), resume → next ms increment after exactly 2 cycles.
- Saturation: reach 23:59:59.999, keep running 20 cycles → outputs hold 23:59:59.999, Overflow_o=1. Then Clear for 1 cycle → all 0, Overflow_o=0.
- Lap coincident with tick: Lap rises in the tick cycle at Milli_o=12'h005 → Lap_Milli_o=12'h005, Milli_o=12'h006, Lap_Valid_o=1. Lap held high for 10 cycles does not recapture.
- Clear priority: Clear=1 and Lap rising in the same cycle while running → all outputs 0, Lap_Valid_o=0. In a build without STOPWATCH_LAP_EN, Lap pulses leave Lap_* at 0.
